// File: rtl/fifo_rr_write_arbiter.sv
// fifo_rr_write_arbiter: round-robin producer arbiter, occupancy mirror and flush sequencer for one FIFO (ARB_PRIO0_EN: requester 0 strict priority)
module fifo_rr_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_IDX_W = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          deq_req,
  output logic                          deq_valid,
  output logic [DATA_WIDTH-1:0]         deq_data,
  input  logic                          flush,
  output logic                          flush_busy,
  output logic [CNT_W-1:0]              occupancy,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          fifo_read,
  input  logic [DATA_WIDTH-1:0]         fifo_rdata
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;
  logic [REQ_IDX_W-1:0] rr_ptr, sel, idx, ptr_next;
  logic [CNT_W-1:0] cnt;
  logic found, run, grant_ok;
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
`ifdef ARB_PRIO0_EN
    found = req_valid[0];
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = REQ_IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
`ifdef ARB_PRIO0_EN
      if (!found && idx != '0 && req_valid[idx]) begin
`else
      if (!found && req_valid[idx]) begin
`endif
        found = 1'b1;
        sel = idx;
      end
    end
  end
`ifdef ARB_PRIO0_EN
  assign ptr_next = sel == '0 ? rr_ptr : sel == REQ_IDX_W'(NUM_REQ - 1) ? REQ_IDX_W'(1) : sel + 1'b1;
`else
  assign ptr_next = sel == REQ_IDX_W'(NUM_REQ - 1) ? '0 : sel + 1'b1;
`endif
  assign run        = state == RUN;
  assign grant_ok   = run && !flush && cnt < CNT_W'(DEPTH);
  assign fifo_write = grant_ok && found;
  assign req_ready  = fifo_write ? {{(NUM_REQ-1){1'b0}}, 1'b1} << sel : '0;
  assign fifo_wdata = fifo_write ? req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign deq_valid  = run && cnt != '0;
  assign fifo_read  = run ? deq_valid && deq_req && !flush : cnt != '0;
  assign deq_data   = fifo_rdata;
  assign flush_busy = !run;
  assign occupancy  = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + CNT_W'(fifo_write) - CNT_W'(fifo_read);
      rr_ptr <= fifo_write ? ptr_next : rr_ptr;
      state  <= run ? (flush ? FLUSH : RUN) : (cnt == '0 ? RUN : FLUSH);
    end
  end
endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// tb_fifo_rr_write_arbiter: randomized scoreboard bench against a queue-based model of the arbiter and its FIFO
module tb_fifo_rr_write_arbiter;
  localparam int N = 4, DW = 32, DEPTH = 16;
  logic clk = 1'b0, rst = 1'b1, deq_req = 1'b0, flush = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic deq_valid, flush_busy, fifo_write, fifo_read;
  logic [DW-1:0] deq_data, fifo_wdata, fifo_rdata;
  logic [4:0] occupancy;
  fifo_rr_write_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .deq_req(deq_req), .deq_valid(deq_valid), .deq_data(deq_data), .flush(flush),
    .flush_busy(flush_busy), .occupancy(occupancy), .fifo_write(fifo_write),
    .fifo_wdata(fifo_wdata), .fifo_read(fifo_read), .fifo_rdata(fifo_rdata)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] mem [DEPTH];
  logic [3:0] wp = '0, rp = '0;
  assign fifo_rdata = mem[rp];
  always @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (fifo_write) begin
        mem[wp] <= fifo_wdata;
        wp <= wp + 1'b1;
      end
      if (fifo_read) rp <= rp + 1'b1;
    end
  end
  typedef struct {
    logic [N-1:0] rdy;
    logic wr;
    logic [DW-1:0] wd;
    logic rd;
    logic dv;
    logic [DW-1:0] dd;
    logic fb;
    logic [4:0] occ;
  } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mq[$];
  bit m_flushing = 0;
  int m_ptr = 0;
  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v);
`ifdef ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
`ifdef ARB_PRIO0_EN
      if (j == 0) continue;
`endif
      if (v[j]) return j;
    end
    return -1;
  endfunction
  task automatic cyc(input logic [N-1:0] v, input logic d, input logic f, input logic r);
    exp_t e;
    int g;
    @(posedge clk);
    #1;
    req_valid = v;
    deq_req = d;
    flush = f;
    rst = r;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    g = (!m_flushing && !f && mq.size() < DEPTH) ? pick(v) : -1;
    e.rdy = g >= 0 ? N'(1) << g : '0;
    e.wr = g >= 0;
    e.wd = g >= 0 ? req_data[g*DW +: DW] : '0;
    e.dv = !m_flushing && mq.size() > 0;
    e.rd = m_flushing ? mq.size() > 0 : (e.dv && d && !f);
    e.dd = mq.size() > 0 ? mq[0] : '0;
    e.fb = m_flushing;
    e.occ = 5'(mq.size());
    exp_q.push_back(e);
    if (r) begin
      mq.delete();
      m_flushing = 0;
      m_ptr = 0;
    end else begin
      if (e.rd) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back(e.wd);
`ifdef ARB_PRIO0_EN
        if (g != 0) m_ptr = (g + 1) % N == 0 ? 1 : g + 1;
`else
        m_ptr = (g + 1) % N;
`endif
      end
      if (m_flushing) m_flushing = mq.size() > 0 || e.rd;
      else m_flushing = f;
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("req_ready", DW'(req_ready), DW'(e.rdy));
      chk("fifo_write", DW'(fifo_write), DW'(e.wr));
      chk("fifo_wdata", fifo_wdata, e.wd);
      chk("fifo_read", DW'(fifo_read), DW'(e.rd));
      chk("deq_valid", DW'(deq_valid), DW'(e.dv));
      if (e.dv) chk("deq_data", deq_data, e.dd);
      chk("flush_busy", DW'(flush_busy), DW'(e.fb));
      chk("occupancy", DW'(occupancy), DW'(e.occ));
    end
  end
  initial begin
    repeat (2) cyc('0, 0, 0, 1);
    repeat (5) cyc(4'b1111, 0, 0, 0);
    repeat (14) cyc(4'($urandom_range(1, 15)), 0, 0, 0);
    cyc(4'b1111, 1, 0, 0);
    repeat (3) cyc(4'b1111, 0, 0, 0);
    repeat (13) cyc('0, 1, 0, 0);
    cyc(4'b0100, 1, 0, 0);
    repeat (2) cyc('0, 1, 0, 0);
    cyc(4'b1111, 0, 1, 0);
    repeat (8) cyc(4'b1111, 1, 1, 0);
    repeat (3) cyc('0, 1, 0, 0);
    cyc('0, 0, 1, 0);
    repeat (3) cyc('0, 0, 0, 0);
    repeat (3) cyc(4'b0111, 0, 0, 0);
    repeat (4) cyc(4'b0110, 0, 0, 0);
    repeat (6) cyc(4'b1111, 0, 0, 0);
    cyc('0, 0, 1, 0);
    repeat (2) cyc(4'b1111, 0, 0, 0);
    cyc('0, 0, 0, 1);
    repeat (4) cyc(4'b1011, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc(4'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 250) == 0);
    repeat (2) cyc('0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
